usr_burst: RTL

Parametrised universal shift register with WIDTH bits, eight operating modes and a counted burst engine. It replaces the fixed 4-bit hold/shift/load register in the register library. It operates in two ways:
- **Continuous:** applies the selected mode on every clock edge.
- **Burst:** on a start request, latches a mode and a count, repeats the operation that many times, and reports busy and done.

It sits between serial links, parallel buses and datapath logic as a general shifter/serialiser.

---
 rtl/usr_burst_if.sv | 28 ++
 rtl/usr_burst.sv | 101 ++++++++++
 2 files changed

// File: rtl/usr_burst_if.sv
// Handshake/data bundle for the usr_burst universal shift register.
// The master side drives mode, data and burst requests; the slave side returns register state.
interface usr_burst_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic [2:0]       mode;
   logic [WIDTH-1:0] par_in;
   logic             sin_lo;
   logic             sin_hi;
   logic             start;
   logic [CNT_W-1:0] shift_count;
   logic [WIDTH-1:0] q;
   logic             sout_lo;
   logic             sout_hi;
   logic             busy;
   logic             done;

   modport master (
      output mode, par_in, sin_lo, sin_hi, start, shift_count,
      input  q, sout_lo, sout_hi, busy, done
   );

   modport slave (
      input  mode, par_in, sin_lo, sin_hi, start, shift_count,
      output q, sout_lo, sout_hi, busy, done
   );
endinterface

// File: rtl/usr_burst.sv
// Parametrised universal shift register with eight modes and a counted burst engine.
// Continuous mode applies the live mode each edge; a burst repeats a latched mode n times.
module usr_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input logic       clk,
   input logic       reset,
   usr_burst_if.slave bus
);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] q_reg;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_r;
   logic             busy_reg;
   logic             done_reg;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] next_q;

   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] par,
      input logic             slo,
      input logic             shi
   );
      logic [WIDTH-1:0] res;
      res = cur;
      case (op)
         3'b000:  res = cur;
         3'b001:  res = {cur[WIDTH-2:0], slo};
         3'b010:  res = {shi, cur[WIDTH-1:1]};
         3'b011:  res = par;
         3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
         3'b101:  res = {cur[0], cur[WIDTH-1:1]};
         3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
         default: res = '0;
      endcase
      return res;
   endfunction

   // During a burst the latched op drives the datapath; the serial/parallel data stay live.
   always_comb begin
      sel_op = (state == BURST) ? op_r : bus.mode;
      next_q = apply_op(sel_op, q_reg, bus.par_in, bus.sin_lo, bus.sin_hi);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         q_reg    <= '0;
         cnt      <= '0;
         op_r     <= 3'b000;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  // The start edge itself never touches q; a zero count just reports done.
                  if (bus.shift_count != '0) begin
                     op_r     <= bus.mode;
                     cnt      <= bus.shift_count;
                     busy_reg <= 1'b1;
                     state    <= BURST;
                  end else begin
                     done_reg <= 1'b1;
                  end
               end else begin
                  q_reg <= next_q;
               end
            end
            BURST: begin
               q_reg    <= next_q;
               cnt      <= cnt - 1'b1;
               done_reg <= 1'b0;
               if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  busy_reg <= 1'b0;
                  done_reg <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.q       = q_reg;
   assign bus.sout_lo = q_reg[0];
   assign bus.sout_hi = q_reg[WIDTH-1];
   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;

endmodule
